fb_write_sched: RTL
===================

# fb_write_sched

Framebuffer write-port scheduler. Shares the single write port of the 256x256x8 framebuffer RAM between two requesters:
- the byte-stream writer fed by the COBS/UART command decoder;
- an internal rectangle-fill engine that clears or paints regions in hardware.

It arbitrates one write per clock with round-robin on contention and drives the RAM `write_enable`/`waddr`/`din` directly.

## Interface
- `ADDR_W`, 16, RAM address width; the address is `{y[7:0], x[7:0]}`.
- `DATA_W`, 8, pixel width (RGB332).
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `s_valid`  in  1  stream write request.
- `s_ready`  out  1  stream granted this cycle; a transfer occurs when `s_valid && s_ready`.
- `s_addr`  in  16  stream write address.
- `s_data`  in  8  stream write data.
- `fill_start`  in  1  one-cycle pulse; starts a fill. Sampled only when the engine is idle.
- `fill_abort`  in  1  stops a running fill.
- `fill_x0`, `fill_y0`  in  8 each  top-left corner of the fill.
- `fill_w`, `fill_h`  in  9 each  fill size; valid range 0..256.
- `fill_color`  in  8  fill pixel value.
- `fill_busy`  out  1  fill engine is not idle.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `ram_we`  out  1  RAM write enable.
- `ram_waddr`  out  16  RAM write address.
- `ram_wdata`  out  8  RAM write data.
- `vblank`  in  1  present only when `FB_VBLANK_GATE_EN` is defined.

## Operation
- Reset values: `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `fill_busy`=0, `fill_done`=0, `s_ready`=0, fill FSM in IDLE, `last_grant`=FILL.
- Requests:
  - Stream request: `s_valid`.
  - Fill request: FSM is in RUN.
- Grant rule:
  - If only one requester is active, grant it.
  - If both are active, grant the requester that was not `last_grant`.
  - `last_grant` updates only on a grant. With `last_grant`=FILL after reset, the stream wins the first tie.
- `s_ready` is combinational: 1 exactly when the stream is granted.
- Fill FSM states are IDLE, RUN and DONE.
- IDLE:
  - On `fill_start`, latch x0, y0, w, h and color.
  - Clear the `col` and `row` counters (9 bits each).
  - Go to RUN. If w==0 or h==0, go directly to DONE.
  - `fill_start` while busy is ignored.
- RUN:
  - Each fill grant issues a write at `{(y0+row) mod 256, (x0+col) mod 256}`.
  - If `col`==w-1, set `col`=0 and increment `row`; otherwise increment `col`.
  - The grant with `col`==w-1 and `row`==h-1 goes to DONE.
  - Row-major order. x and y each wrap within 0..255; no write ever falls outside the 64 KiB space.
- DONE: `fill_done`=1 for one cycle, then go to IDLE.
- `fill_abort` in RUN or DONE:
  - Go to IDLE next edge with no `fill_done` pulse.
  - A write granted in the abort cycle still completes.
- Asynchronous reset mid-fill or mid-stream returns to reset values immediately. A pending stream beat is not written.
- `fill_busy` = (state != IDLE).

## Timing
- Stream: a transfer in cycle c gives `ram_we`=1, `ram_waddr`=`s_addr`, `ram_wdata`=`s_data` in cycle c+1. Outputs are registered.
- `ram_we` is 0 in any cycle following a cycle with no grant. `ram_waddr`/`ram_wdata` hold their last values.
- Fill, uncontended, with `fill_start` in cycle k:
  - RUN from cycle k+1.
  - Grants in cycles k+1 .. k+w*h.
  - Writes visible in cycles k+2 .. k+w*h+1.
  - `fill_done` in cycle k+w*h+1, coincident with the last write.
  - IDLE in cycle k+w*h+2.
- Fill with w or h zero: `fill_done` in cycle k+1, no writes.
- Contended throughput: requesters alternate, one write each per two cycles. Neither requester starves.
- Simultaneous `fill_start` and stream traffic: the start cycle itself grants the stream, because the fill does not request until RUN.

## Configuration
- `FB_VBLANK_GATE_EN` defined:
  - The `vblank` input exists.
  - Grants are issued only in cycles with `vblank`=1. In other cycles `s_ready`=0, no write occurs, and the `last_grant` and fill counters hold.
  - A fill therefore stalls across active video and resumes in the next blanking interval.
- `FB_VBLANK_GATE_EN` undefined: no `vblank` port; grants are issued every cycle as described above.

## Test plan
- Reset, then stream beat addr=0x1234, data=0xA5 at cycle c -> `ram_we`=1, `ram_waddr`=0x1234, `ram_wdata`=0xA5 at c+1 only. All outputs are 0 before the beat.
- Fill x0=0xFE, y0=0xFF, w=3, h=2, color=0x1C, stream idle -> six writes, in order, at 0xFFFE, 0xFFFF, 0xFF00, 0x00FE, 0x00FF, 0x0000. `fill_done` coincides with the 6th write. `fill_busy` is 1 for exactly 7 cycles.
- Fill w=4, h=1 with `s_valid` held high -> stream wins the first tie. Granted sources alternate S,F,S,F,S,F,S,F, and the fill completes in 8 grant cycles.
- Fill w=256, h=256 with `fill_abort` at grant #1000 -> exactly 1000 fill writes, `fill_busy` falls next cycle, no `fill_done`. A second `fill_start` is then accepted.
- Edge cases: `fill_start` with w=0 -> `fill_done` at k+1 and no `ram_we`. A `fill_start` pulsed while busy -> ignored, and the write count is unchanged.
- With `FB_VBLANK_GATE_EN`, `vblank` low for 10 cycles mid-fill -> no writes and `s_ready`=0 during those cycles. The fill resumes at the next address when `vblank` rises.

Source files
------------

// File: rtl/fb_write_sched.sv
// Framebuffer write-port scheduler: round-robin between the command byte
// stream and a rectangle-fill engine, one RAM write per clock.
// Optional feature macro: FB_VBLANK_GATE_EN (grants only while vblank=1).
module fb_write_sched #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FB_VBLANK_GATE_EN
  input  logic              vblank,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [7:0]        fill_x0,
  input  logic [7:0]        fill_y0,
  input  logic [8:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
);

  localparam int unsigned COORD_W = 8;
  localparam int unsigned CNT_W   = 9;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // last_grant encoding: 1 = fill, 0 = stream
  localparam logic LG_FILL   = 1'b1;
  localparam logic LG_STREAM = 1'b0;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0]    w_q, w_d, h_q, h_d;
  logic [COORD_W-1:0]  x0_q, x0_d, y0_q, y0_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic                last_grant_q, last_grant_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                gate_c;
  logic                grant_s_c, grant_f_c;
  logic [COORD_W-1:0]  fill_x_c, fill_y_c;

`ifdef FB_VBLANK_GATE_EN
  assign gate_c = vblank;
`else
  assign gate_c = 1'b1;
`endif

  // Arbitration: single requester wins; on a tie the one not granted last wins
  always_comb begin
    grant_s_c = 1'b0;
    grant_f_c = 1'b0;
    if (gate_c) begin
      if (s_valid && (state_q != ST_RUN || last_grant_q == LG_FILL)) begin
        grant_s_c = 1'b1;
      end else if (state_q == ST_RUN) begin
        grant_f_c = 1'b1;
      end
    end
  end

  // Fill pixel coordinates wrap within the 256x256 plane
  assign fill_x_c = x0_q + COORD_W'(col_q);
  assign fill_y_c = y0_q + COORD_W'(row_q);

  assign s_ready   = grant_s_c;
  assign fill_busy = (state_q != ST_IDLE);
  assign fill_done = (state_q == ST_DONE) && !fill_abort;
  assign ram_we    = ram_we_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_wdata = ram_wdata_q;

  // Fill FSM next state, raster counters and RAM write register next values
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    w_d          = w_q;
    h_d          = h_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    color_d      = color_q;
    last_grant_d = last_grant_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          x0_d    = fill_x0;
          y0_d    = fill_y0;
          w_d     = fill_w;
          h_d     = fill_h;
          color_d = fill_color;
          col_d   = '0;
          row_d   = '0;
          state_d = (fill_w == '0 || fill_h == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (grant_f_c) begin
          if (col_q == w_q - CNT_W'(1)) begin
            col_d = '0;
            row_d = row_q + CNT_W'(1);
            if (row_q == h_q - CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (fill_abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end

    if (grant_s_c) begin
      ram_we_d     = 1'b1;
      ram_waddr_d  = s_addr;
      ram_wdata_d  = s_data;
      last_grant_d = LG_STREAM;
    end else if (grant_f_c) begin
      ram_we_d     = 1'b1;
      ram_waddr_d  = ADDR_W'({fill_y_c, fill_x_c});
      ram_wdata_d  = color_q;
      last_grant_d = LG_FILL;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      w_q          <= '0;
      h_q          <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      color_q      <= '0;
      last_grant_q <= LG_FILL;
      ram_we_q     <= 1'b0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_q          <= w_d;
      h_q          <= h_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      color_q      <= color_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

endmodule
